// File: rtl/game_pkg.sv
// Shared types, constants and index helpers for the 2048 board engine.
package game_pkg;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef logic [3:0] cell_t;
  typedef cell_t [3:0] line_t;
  typedef enum logic [2:0] {INIT, IDLE, SHIFT, SPAWN, CHECK} state_t;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Board index of position p in line k; p = 0 is the edge the tiles slide toward.
  function automatic logic [3:0] cell_index(input dir_t d, input logic [1:0] k, input logic [1:0] p);
    case (d)
      UP:      return {p, k};
      DOWN:    return {~p, k};
      LEFT:    return {k, p};
      default: return {k, ~p};
    endcase
  endfunction

endpackage

// File: rtl/row_merge.sv
// Combinational slide-and-merge of one 4-cell line toward position 0.
module row_merge
  import game_pkg::*;
(
  input  line_t      line_in,
  output line_t      line_out,
  output logic [3:0] merged
);

  cell_t      comp [5];
  logic [2:0] cnt;
  logic [2:0] o;
  logic       skip;

  always_comb begin
    for (int i = 0; i < 5; i++) comp[i] = '0;
    cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (line_in[i] != '0) begin
        comp[cnt] = line_in[i];
        cnt = cnt + 3'd1;
      end
    end

    // comp[4] stays zero, so the last tile never finds a partner.
    line_out = '0;
    merged   = '0;
    o        = '0;
    skip     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != '0) begin
        if (comp[i] == comp[i+1]) begin
          line_out[o[1:0]] = (comp[i] == 4'hF) ? 4'hF : comp[i] + 4'd1;
          merged[o[1:0]]   = 1'b1;
          skip             = 1'b1;
        end else begin
          line_out[o[1:0]] = comp[i];
        end
        o = o + 3'd1;
      end
    end
  end

endmodule

// File: rtl/game_board_2048.sv
// 4x4 2048 game-state engine: move sequencing, tile spawn, win/lose detection.
// Optional GAME_SCORE_EN adds a saturating score output.
module game_board_2048
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          WIN_EXP       = 11,
  parameter int          SPAWN4_THRESH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic [63:0] vals,
  output logic        gameover,
`ifdef GAME_SCORE_EN
  output logic        gamecompleted,
  output logic [15:0] score
`else
  output logic        gamecompleted
`endif
);

  localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0) ? LFSR_DEFAULT : LFSR_SEED;
  localparam cell_t       WIN_CELL   = cell_t'(WIN_EXP);
  localparam logic [3:0]  SPAWN4_LIM = 4'(SPAWN4_THRESH);

  state_t           state_q, state_d;
  cell_t [15:0]     board_q, board_d;
  logic [15:0]      lfsr_q, lfsr_d;
  dir_t             dir_q, dir_d;
  logic [1:0]       k_q, k_d;
  logic             changed_q, changed_d;
  logic [3:0]       cursor_q, cursor_d;
  logic [3:0]       scan_q, scan_d;
  logic             second_q, second_d;
  logic             over_q, over_d;
  logic             win_q, win_d;

  line_t            line_in, line_out;
  logic [3:0]       merge_mask;
  logic             spawn_done;
  cell_t            spawn_exp;
  logic             has_empty, has_pair, has_win;

  row_merge u_row_merge (
    .line_in  (line_in),
    .line_out (line_out),
    .merged   (merge_mask)
  );

  always_comb begin
    for (int p = 0; p < 4; p++) line_in[p] = board_q[cell_index(dir_q, k_q, 2'(p))];
  end

  always_comb begin
    has_empty = 1'b0;
    has_win   = 1'b0;
    has_pair  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (board_q[i] == '0) has_empty = 1'b1;
      if (board_q[i] >= WIN_CELL) has_win = 1'b1;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (board_q[r*4+c] == board_q[r*4+c+1]) has_pair = 1'b1;
    for (int i = 0; i < 12; i++)
      if (board_q[i] == board_q[i+4]) has_pair = 1'b1;
  end

  assign spawn_exp = ({1'b0, lfsr_q[6:4]} < SPAWN4_LIM) ? 4'd2 : 4'd1;

`ifdef GAME_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [17:0] gain, score_sum;

  always_comb begin
    gain = '0;
    for (int p = 0; p < 4; p++)
      if (merge_mask[p]) gain = gain + (18'd1 << line_out[p]);
    score_sum = {2'b00, score_q} + gain;
  end

  assign score = score_q;
`else
  logic unused_merge;
  assign unused_merge = ^merge_mask;
`endif

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    lfsr_d     = lfsr_step(lfsr_q);
    dir_d      = dir_q;
    k_d        = k_q;
    changed_d  = changed_q;
    cursor_d   = cursor_q;
    scan_d     = scan_q;
    second_d   = second_q;
    over_d     = over_q;
    win_d      = win_q;
    spawn_done = 1'b0;
`ifdef GAME_SCORE_EN
    score_d    = score_q;
`endif

    case (state_q)
      INIT: begin
        state_d  = SPAWN;
        cursor_d = lfsr_q[3:0];
        scan_d   = '0;
        second_d = 1'b1;
      end

      IDLE: begin
        if (move_valid && move_ready) begin
          dir_d     = dir_t'(move_dir);
          changed_d = 1'b0;
          k_d       = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        for (int p = 0; p < 4; p++) board_d[cell_index(dir_q, k_q, 2'(p))] = line_out[p];
        changed_d = changed_q | (line_out != line_in);
`ifdef GAME_SCORE_EN
        score_d = (score_sum > 18'h0FFFF) ? 16'hFFFF : score_sum[15:0];
`endif
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          if (changed_d) begin
            state_d  = SPAWN;
            cursor_d = lfsr_q[3:0];
            scan_d   = '0;
          end else begin
            state_d = CHECK;
          end
        end
      end

      SPAWN: begin
        if (board_q[cursor_q] == '0) begin
          board_d[cursor_q] = spawn_exp;
          spawn_done        = 1'b1;
        end else begin
          cursor_d = cursor_q + 4'd1;
          scan_d   = scan_q + 4'd1;
          if (scan_q == 4'hF) spawn_done = 1'b1;
        end
        // The power-up sequence runs the spawn scan twice back to back.
        if (spawn_done) begin
          if (second_q) begin
            second_d = 1'b0;
            cursor_d = lfsr_q[3:0];
            scan_d   = '0;
          end else begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        win_d   = win_q | has_win;
        over_d  = over_q | (!has_empty && !has_pair);
        state_d = IDLE;
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      board_q   <= '0;
      lfsr_q    <= SEED;
      dir_q     <= LEFT;
      k_q       <= '0;
      changed_q <= 1'b0;
      cursor_q  <= '0;
      scan_q    <= '0;
      second_q  <= 1'b0;
      over_q    <= 1'b0;
      win_q     <= 1'b0;
`ifdef GAME_SCORE_EN
      score_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      lfsr_q    <= lfsr_d;
      dir_q     <= dir_d;
      k_q       <= k_d;
      changed_q <= changed_d;
      cursor_q  <= cursor_d;
      scan_q    <= scan_d;
      second_q  <= second_d;
      over_q    <= over_d;
      win_q     <= win_d;
`ifdef GAME_SCORE_EN
      score_q   <= score_d;
`endif
    end
  end

  assign vals          = board_q;
  assign move_ready    = (state_q == IDLE) && !over_q && !win_q;
  assign gameover      = over_q;
  assign gamecompleted = win_q;

endmodule
